// File: rtl/stk_pkg.sv
// Shared types for the stack command interface: opcodes, engine ids,
// SRAM pointer fields and the response/tag records used by stk_rsp_eng.
package stk_pkg;

  localparam int C_RD_LAT = 2;
  localparam int C_W      = 32;
  localparam int C_Q_N    = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_INV  = 2'd3
  } opcode_t;

  typedef logic [2:0] engid_t;
  typedef logic [1:0] bank_id_t;
  typedef logic [8:0] line_id_t;

  // Location of the top-of-stack entry in the banked SRAM.
  typedef struct packed {
    bank_id_t bnk;
    line_id_t line;
  } ptr_t;

  // Response sideband stored next to the data word in the response queue.
  typedef struct packed {
    engid_t engid;
    logic   err;
  } rsp_t;

  // One slot of the fixed-latency tag pipeline.
  typedef struct packed {
    logic   vld;
    engid_t engid;
    logic   is_rd;
    logic   err;
  } tag_t;

endpackage

// File: rtl/stk_rsp_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and a registered head word.
// The head register always shows the oldest entry, so the consumer sees a
// flop output and the head is stable while it is not being popped.
module stk_rsp_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = head_q;

  // Pointer advance and look-ahead of the next head word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    // A write landing in the slot that becomes the head must bypass the array.
    if (push_ok && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) head_d = push_data;
    else                                               head_d = mem_q[rptr_d[AW-1:0]];
  end

  // Pointer and head registers.
  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!arst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; occupancy lives in the pointers, so stale words are never observed.
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/stk_rsp_eng.sv
// Response end of the stack command interface. Accepted commands issue SRAM
// reads (POP on a non-empty stack), travel through a fixed-latency tag
// pipeline so every class sees the same delay, and land in a credit-bounded
// response FIFO whose head drives the engine response bus.
module stk_rsp_eng
  import stk_pkg::*;
#(
  parameter int W      = C_W,
  parameter int RD_LAT = C_RD_LAT,
  parameter int Q_N    = C_Q_N
) (
  input  logic     clk,
  input  logic     arst_n,
  input  logic     cmd_vld,
  input  opcode_t  cmd_opcode,
  input  engid_t   cmd_engid,
  input  ptr_t     cmd_ptr,
  input  logic     cmd_empty,
  output logic     cmd_rdy,
  output logic     rd_en,
  output bank_id_t rd_bnk,
  output line_id_t rd_addr,
  input  logic [W-1:0] rd_dat,
  output logic     rsp_vld,
  output engid_t   rsp_engid,
  output logic [W-1:0] rsp_dat,
  output logic     rsp_err,
  input  logic     rsp_rdy
);

  localparam int CW = $clog2(Q_N) + 1;
  localparam int RW = $bits(rsp_t);
  localparam int FW = RW + W;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_en_q, rd_en_d;
  bank_id_t      rd_bnk_q, rd_bnk_d;
  line_id_t      rd_addr_q, rd_addr_d;
  tag_t          tag_q [RD_LAT+1];
  tag_t          tag_d [RD_LAT+1];

  logic          acc;
  logic          rsp_bearing;
  logic          is_rd;
  logic          rsp_hs;
  tag_t          cap;
  rsp_t          wr_rsp;
  rsp_t          head_rsp;
  logic [W-1:0]  wr_dat;
  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  // Ready depends on the registered credit count only, never on rsp_rdy.
  assign cmd_rdy     = (cnt_q != CW'(Q_N));
  assign acc         = cmd_vld && cmd_rdy;
  assign rsp_bearing = acc && (cmd_opcode != OP_NOP);
  assign is_rd       = acc && (cmd_opcode == OP_POP) && !cmd_empty;
  assign rsp_hs      = rsp_vld && rsp_rdy;
  assign cap         = tag_q[RD_LAT];

  // Credit count: +1 per response-bearing accept, -1 per response handshake.
  always_comb begin
    cnt_d = cnt_q;
    case ({rsp_bearing, rsp_hs})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Read request for the next cycle; address holds its last value when idle.
  always_comb begin
    rd_en_d   = is_rd;
    rd_bnk_d  = rd_bnk_q;
    rd_addr_d = rd_addr_q;
    if (is_rd) begin
      rd_bnk_d  = cmd_ptr.bnk;
      rd_addr_d = cmd_ptr.line;
    end
  end

  // Tag pipeline: a new tag enters at stage 0 and shifts one stage per cycle.
  always_comb begin
    tag_d[0] = '0;
    if (rsp_bearing) begin
      tag_d[0].vld   = 1'b1;
      tag_d[0].engid = cmd_engid;
      tag_d[0].is_rd = is_rd;
      tag_d[0].err   = (cmd_opcode == OP_INV) ||
                       ((cmd_opcode == OP_POP) && cmd_empty);
    end
    for (int i = 1; i <= RD_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  // Credit, read-port and tag registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_bnk_q  <= '0;
      rd_addr_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rd_en_q   <= rd_en_d;
      rd_bnk_q  <= rd_bnk_d;
      rd_addr_q <= rd_addr_d;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_bnk  = rd_bnk_q;
  assign rd_addr = rd_addr_q;

  // Capture stage: rd_dat is only taken when the tag there owns a read.
  always_comb begin
    wr_rsp.engid = cap.engid;
    wr_rsp.err   = cap.err;
    wr_dat       = cap.is_rd ? rd_dat : '0;
    fifo_din     = {wr_rsp, wr_dat};
  end

  stk_rsp_fifo #(
    .DW    (FW),
    .DEPTH (Q_N)
  ) u_rsp_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (cap.vld),
    .push_data (fifo_din),
    .pop       (rsp_rdy),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_rsp  = rsp_t'(fifo_head[FW-1 -: RW]);
  assign rsp_vld   = !fifo_empty;
  assign rsp_engid = head_rsp.engid;
  assign rsp_err   = head_rsp.err;
  assign rsp_dat   = fifo_head[W-1:0];

  // Credits bound the number of tags in flight, so the queue can never overflow.
  a_no_overflow : assert property (@(posedge clk) disable iff (!arst_n)
    !(cap.vld && fifo_full));

endmodule

// File: tb/tb_stk_rsp_eng.sv
// Bench for stk_rsp_eng: directed scenarios plus a random stream, all checked
// against a transaction-level model (SRAM array, expected-response queue,
// outstanding-credit count) that is updated at mid-cycle.
module tb_stk_rsp_eng;
  import stk_pkg::*;

  localparam int W      = 32;
  localparam int RD_LAT = 2;
  localparam int Q_N    = 4;

  logic     clk = 1'b0;
  logic     arst_n = 1'b0;
  logic     cmd_vld = 1'b0;
  opcode_t  cmd_opcode = OP_NOP;
  engid_t   cmd_engid = '0;
  ptr_t     cmd_ptr = '0;
  logic     cmd_empty = 1'b0;
  logic     cmd_rdy;
  logic     rd_en;
  bank_id_t rd_bnk;
  line_id_t rd_addr;
  logic [W-1:0] rd_dat = '0;
  logic     rsp_vld;
  engid_t   rsp_engid;
  logic [W-1:0] rsp_dat;
  logic     rsp_err;
  logic     rsp_rdy = 1'b1;

  always #5 clk = ~clk;

  stk_rsp_eng #(.W(W), .RD_LAT(RD_LAT), .Q_N(Q_N)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .cmd_vld    (cmd_vld),
    .cmd_opcode (cmd_opcode),
    .cmd_engid  (cmd_engid),
    .cmd_ptr    (cmd_ptr),
    .cmd_empty  (cmd_empty),
    .cmd_rdy    (cmd_rdy),
    .rd_en      (rd_en),
    .rd_bnk     (rd_bnk),
    .rd_addr    (rd_addr),
    .rd_dat     (rd_dat),
    .rsp_vld    (rsp_vld),
    .rsp_engid  (rsp_engid),
    .rsp_dat    (rsp_dat),
    .rsp_err    (rsp_err),
    .rsp_rdy    (rsp_rdy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    engid_t       engid;
    logic [W-1:0] dat;
    logic         err;
    int           due;
  } exp_t;

  typedef struct packed {
    logic     en;
    bank_id_t bnk;
    line_id_t addr;
  } req_t;

  logic [W-1:0] sram [4][512];
  exp_t  sb[$];
  req_t  ring [8];
  req_t  rq;
  int    cyc = 16;
  int    mcnt = 0;
  int    rsp_seen = 0;
  logic  prev_rd = 1'b0;
  ptr_t  prev_ptr = '0;

  initial begin
    for (int b = 0; b < 4; b++)
      for (int l = 0; l < 512; l++) sram[b][l] = $urandom();
    sram[2][9'h155] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) ring[i] = '0;
  end

  // SRAM model: a read strobed in cycle c returns data during cycle c+RD_LAT;
  // every other cycle carries junk that the design must ignore.
  always @(posedge clk) begin
    cyc++;
    #1;
    rq = ring[(cyc - RD_LAT) % 8];
    rd_dat = rq.en ? sram[rq.bnk][rq.addr] : $urandom();
  end

  // Mid-cycle monitor: checks outputs against the model, then applies this
  // cycle's handshakes to the model.
  always @(negedge clk) begin
    ring[cyc % 8] = '{en: rd_en, bnk: rd_bnk, addr: rd_addr};
    if (!arst_n) begin
      sb.delete();
      mcnt    = 0;
      prev_rd = 1'b0;
    end else begin
      check("cmd_rdy", cmd_rdy, (mcnt != Q_N));
      check("rd_en", rd_en, prev_rd);
      if (prev_rd) begin
        check("rd_bnk", rd_bnk, prev_ptr.bnk);
        check("rd_addr", rd_addr, prev_ptr.line);
      end
      if (sb.size() > 0 && sb[0].due <= cyc) check("rsp_vld_due", rsp_vld, 1'b1);
      if (rsp_vld) begin
        if (sb.size() == 0) check("rsp_spurious", rsp_vld, 1'b0);
        else begin
          check("rsp_early", (cyc >= sb[0].due), 1'b1);
          check("rsp_engid", rsp_engid, sb[0].engid);
          check("rsp_dat", rsp_dat, sb[0].dat);
          check("rsp_err", rsp_err, sb[0].err);
        end
      end
      if (rsp_vld && rsp_rdy && sb.size() > 0) begin
        void'(sb.pop_front());
        mcnt--;
        rsp_seen++;
      end
      prev_rd = 1'b0;
      if (cmd_vld && cmd_rdy && cmd_opcode != OP_NOP) begin
        exp_t e;
        e.engid = cmd_engid;
        e.due   = cyc + RD_LAT + 2;
        e.dat   = '0;
        e.err   = 1'b0;
        case (cmd_opcode)
          OP_POP: begin
            if (cmd_empty) e.err = 1'b1;
            else begin
              e.dat    = sram[cmd_ptr.bnk][cmd_ptr.line];
              prev_rd  = 1'b1;
              prev_ptr = cmd_ptr;
            end
          end
          OP_INV:  e.err = 1'b1;
          default: e.err = 1'b0;
        endcase
        sb.push_back(e);
        mcnt++;
        check("cnt_le_qn", (mcnt <= Q_N), 1'b1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input opcode_t op, input engid_t e, input bank_id_t b,
                       input line_id_t l, input logic emp);
    cmd_vld    = 1'b1;
    cmd_opcode = op;
    cmd_engid  = e;
    cmd_ptr    = '{bnk: b, line: l};
    cmd_empty  = emp;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_rdy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("issue_timeout", cmd_rdy, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_vld    = 1'b0;
    cmd_opcode = OP_NOP;
  endtask

  task automatic drain();
    rsp_rdy = 1'b1;
    for (int k = 0; k < 200 && sb.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"}, cmd_rdy, 1'b1);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_rd_bnk"}, rd_bnk, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_rsp_vld"}, rsp_vld, 1'b0);
    check({tag, "_rsp_engid"}, rsp_engid, 0);
    check({tag, "_rsp_dat"}, rsp_dat, 0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int          base;
    int          rd_pulses;
    int          acc_n;
    int          cyc_n;
    logic        took;
    engid_t      got_e[$];
    logic        got_err[$];
    logic [W-1:0] got_d[$];

    repeat (3) @(posedge clk);
    #3 arst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    // 1: single POP, read issue and response latency.
    rsp_rdy = 1'b1;
    issue(OP_POP, 3'd3, 2'd2, 9'h155, 1'b0);
    idle();
    @(negedge clk);
    check("t1_rd_en", rd_en, 1'b1);
    check("t1_rd_bnk", rd_bnk, 2);
    check("t1_rd_addr", rd_addr, 9'h155);
    @(negedge clk);
    @(negedge clk);
    check("t1_vld_t3", rsp_vld, 1'b0);
    @(negedge clk);
    check("t1_vld_t4", rsp_vld, 1'b1);
    check("t1_engid", rsp_engid, 3);
    check("t1_dat", rsp_dat, 32'hDEADBEEF);
    check("t1_err", rsp_err, 1'b0);
    @(posedge clk);
    #1;

    // 2: non-read classes back to back.
    issue(OP_PUSH, 3'd1, 2'd0, 9'd0, 1'b0);
    issue(OP_POP,  3'd2, 2'd1, 9'd3, 1'b1);
    issue(OP_INV,  3'd4, 2'd0, 9'd0, 1'b0);
    issue(OP_NOP,  3'd5, 2'd0, 9'd0, 1'b0);
    idle();
    rd_pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rd_en) rd_pulses++;
      if (rsp_vld && rsp_rdy) begin
        got_e.push_back(rsp_engid);
        got_err.push_back(rsp_err);
        got_d.push_back(rsp_dat);
      end
    end
    @(posedge clk);
    #1;
    check("t2_rd_pulses", rd_pulses, 0);
    check("t2_rsp_count", got_e.size(), 3);
    if (got_e.size() == 3) begin
      check("t2_e1", {got_e[0], got_err[0], got_d[0]}, {3'd1, 1'b0, 32'd0});
      check("t2_e2", {got_e[1], got_err[1], got_d[1]}, {3'd2, 1'b1, 32'd0});
      check("t2_e4", {got_e[2], got_err[2], got_d[2]}, {3'd4, 1'b1, 32'd0});
    end

    // 3: stall with six POPs.
    rsp_rdy = 1'b0;
    base = rsp_seen;
    for (int i = 0; i < 4; i++) issue(OP_POP, engid_t'(i), bank_id_t'(i), line_id_t'(i * 7 + 1), 1'b0);
    cmd_vld    = 1'b1;
    cmd_opcode = OP_POP;
    cmd_engid  = 3'd4;
    cmd_ptr    = '{bnk: 2'd0, line: 9'd29};
    cmd_empty  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t3_rdy_low", cmd_rdy, 1'b0);
      check("t3_hold_vld", rsp_vld, 1'b1);
      check("t3_hold_engid", rsp_engid, 0);
      check("t3_hold_dat", rsp_dat, sram[0][1]);
    end
    @(posedge clk);
    #1;
    rsp_rdy = 1'b1;
    issue(OP_POP, 3'd4, 2'd0, 9'd29, 1'b0);
    issue(OP_POP, 3'd5, 2'd1, 9'd36, 1'b0);
    idle();
    for (int k = 0; k < 40 && (rsp_seen - base) < 6; k++) begin
      @(posedge clk);
      #1;
    end
    check("t3_rsp_count", rsp_seen - base, 6);

    // 4: consume and request in the same cycle at full credit.
    rsp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) issue(OP_POP, engid_t'(i + 2), 2'd3, line_id_t'(i + 100), 1'b0);
    idle();
    repeat (6) @(posedge clk);
    #1;
    rsp_rdy    = 1'b1;
    cmd_vld    = 1'b1;
    cmd_opcode = OP_PUSH;
    cmd_engid  = 3'd6;
    cmd_empty  = 1'b0;
    @(negedge clk);
    check("t4_no_acc_at_full", cmd_rdy, 1'b0);
    @(posedge clk);
    #1;
    rsp_rdy = 1'b0;
    @(negedge clk);
    check("t4_acc_next", cmd_rdy, 1'b1);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    check("t4_cnt_back_full", cmd_rdy, 1'b0);
    @(posedge clk);
    #1;
    drain();

    // 5: reset with reads in flight.
    rsp_rdy = 1'b1;
    issue(OP_POP, 3'd1, 2'd1, 9'd11, 1'b0);
    issue(OP_POP, 3'd2, 2'd2, 9'd22, 1'b0);
    issue(OP_POP, 3'd3, 2'd3, 9'd33, 1'b0);
    idle();
    #1 arst_n = 1'b0;
    @(posedge clk);
    #3 arst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t5_no_stale", rsp_vld, 1'b0);
    end
    @(posedge clk);
    #1;

    // 6: random stream with random back-pressure.
    acc_n = 0;
    cyc_n = 0;
    took  = 1'b0;
    cmd_vld = 1'b0;
    while (acc_n < 1000 && cyc_n < 20000) begin
      if (!cmd_vld || took) begin
        cmd_vld    = ($urandom_range(0, 7) != 0);
        cmd_opcode = opcode_t'($urandom_range(0, 3));
        cmd_engid  = engid_t'($urandom_range(0, 7));
        cmd_ptr    = '{bnk: bank_id_t'($urandom_range(0, 3)), line: line_id_t'($urandom_range(0, 511))};
        cmd_empty  = ($urandom_range(0, 3) == 0);
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = cmd_vld && cmd_rdy;
      if (took) acc_n++;
      @(posedge clk);
      #1;
      cyc_n++;
    end
    idle();
    check("t6_accepted", acc_n, 1000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
